// File: rtl/i2s_transmitter_pkg.sv
// Shared constants and types for the I2S transmitter.
package i2s_transmitter_pkg;

  // Width of one channel slot in bit clocks.
  localparam int SLOT_W    = 32;
  // Bit clocks per stereo frame (left slot + right slot).
  localparam int FRAME_LEN = 64;

  // Bit position within a frame, 0..FRAME_LEN-1.
  typedef logic [5:0] bitcnt_t;

  localparam bitcnt_t CNT_LAST = 6'd63;

endpackage

// File: rtl/i2s_transmitter_sample_fifo.sv
// Sample FIFO feeding the I2S frame register.
// DEPTH must be a power of two, at least 2. A push while full is accepted
// only when a pop happens in the same cycle (the slot is freed as it is filled).
module sample_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q, wr_d;
  logic [AW:0]      rd_q, rd_d;
  logic             do_push, do_pop;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign data_o  = mem_q[rd_q[AW-1:0]];

  // Pointer next-state: extra MSB distinguishes full from empty.
  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (do_push) wr_d = wr_q + (AW+1)'(1);
    if (do_pop)  rd_d = rd_q + (AW+1)'(1);
  end

  // Pointer registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Storage; contents are don't-care while the pointers say empty.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/i2s_transmitter.sv
// Mono-to-stereo I2S transmitter with sample FIFO and sticky status flags.
// Build option: define I2S_SATURATE_EN to clamp out-of-range samples to the
// DATA_BITS signed range instead of truncating to the low bits.
module i2s_transmitter
  import i2s_transmitter_pkg::*;
#(
  parameter int CLK_DIV    = 16,
  parameter int DATA_BITS  = 16,
  parameter int FRAC_SHIFT = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic [31:0] audio_in,
  input  logic        audio_valid_in,
  input  logic        clear_flags_in,
  output logic        sclk_out,
  output logic        lrclk_out,
  output logic        sdata_out,
  output logic        underrun_out,
  output logic        overflow_out
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0]     div_q, div_d;
  logic                 sclk_q, sclk_d;
  bitcnt_t              cnt_q, cnt_d;
  logic                 lrclk_q, lrclk_d;
  logic                 sdata_q, sdata_d;
  logic [DATA_BITS-1:0] frame_q, frame_d;
  logic                 underrun_q, underrun_d;
  logic                 overflow_q, overflow_d;

  logic                 tick, fall, frame_start;
  logic                 fifo_full, fifo_empty;
  logic [DATA_BITS-1:0] fifo_data;
  logic [DATA_BITS-1:0] word;
  logic signed [SLOT_W-1:0] shifted;
  logic                 unused_shift_bits;

  assign tick        = (div_q == DIV_LAST);
  assign fall        = tick && sclk_q;
  assign frame_start = fall && (cnt_q == CNT_LAST);

  // ---------------- sample width reduction ----------------
  assign shifted           = $signed(audio_in) >>> FRAC_SHIFT;
  assign unused_shift_bits = ^shifted;

`ifdef I2S_SATURATE_EN
  localparam logic signed [SLOT_W-1:0] SAT_MAX =
    (DATA_BITS >= SLOT_W) ? 32'sh7FFF_FFFF : ((32'sd1 <<< (DATA_BITS-1)) - 32'sd1);
  localparam logic signed [SLOT_W-1:0] SAT_MIN = -SAT_MAX - 32'sd1;

  // Clamp to the signed DATA_BITS range, else keep the low bits.
  always_comb begin
    word = shifted[DATA_BITS-1:0];
    if (shifted > SAT_MAX)      word = SAT_MAX[DATA_BITS-1:0];
    else if (shifted < SAT_MIN) word = SAT_MIN[DATA_BITS-1:0];
  end
`else
  assign word = shifted[DATA_BITS-1:0];
`endif

  // ---------------- sample FIFO ----------------
  sample_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_in),
    .rst_n_i (rst_n_in),
    .push_i  (audio_valid_in),
    .pop_i   (frame_start),
    .data_i  (word),
    .data_o  (fifo_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Bit clock, frame counter and serializer next-state.
  always_comb begin
    int n;
    int pos;
    logic sel;
    logic [DATA_BITS-1:0] sh;
    div_d   = div_q + DIV_W'(1);
    sclk_d  = sclk_q;
    cnt_d   = cnt_q;
    lrclk_d = lrclk_q;
    sdata_d = sdata_q;
    frame_d = frame_q;
    n       = 0;
    pos     = 0;
    sel     = 1'b0;
    sh      = '0;
    if (tick) begin
      div_d  = '0;
      sclk_d = ~sclk_q;
    end
    if (fall) begin
      cnt_d   = cnt_q + 6'd1;
      lrclk_d = cnt_d[5];
      // On underrun the previous word is simply kept for replay.
      if (frame_start && !fifo_empty) frame_d = fifo_data;
      // Slot bits start one bit clock after each word-select change.
      n = int'(cnt_d);
      if (n >= 1 && n <= DATA_BITS) begin
        sel = 1'b1;
        pos = n - 1;
      end else if (n >= SLOT_W + 1 && n <= SLOT_W + DATA_BITS) begin
        sel = 1'b1;
        pos = n - (SLOT_W + 1);
      end
      sh      = frame_q << pos;
      sdata_d = sel & sh[DATA_BITS-1];
    end
  end

  // Sticky flags: a set event in the same cycle beats a clear.
  always_comb begin
    underrun_d = underrun_q;
    overflow_d = overflow_q;
    if (clear_flags_in) begin
      underrun_d = 1'b0;
      overflow_d = 1'b0;
    end
    if (frame_start && fifo_empty)                     underrun_d = 1'b1;
    if (audio_valid_in && fifo_full && !frame_start)   overflow_d = 1'b1;
  end

  // State registers; the counter parks at 63 so the first fall starts a frame.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      div_q      <= '0;
      sclk_q     <= 1'b0;
      cnt_q      <= CNT_LAST;
      lrclk_q    <= 1'b1;
      sdata_q    <= 1'b0;
      frame_q    <= '0;
      underrun_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      div_q      <= div_d;
      sclk_q     <= sclk_d;
      cnt_q      <= cnt_d;
      lrclk_q    <= lrclk_d;
      sdata_q    <= sdata_d;
      frame_q    <= frame_d;
      underrun_q <= underrun_d;
      overflow_q <= overflow_d;
    end
  end

  assign sclk_out     = sclk_q;
  assign lrclk_out    = lrclk_q;
  assign sdata_out    = sdata_q;
  assign underrun_out = underrun_q;
  assign overflow_out = overflow_q;

endmodule

// File: tb/tb_i2s_transmitter.sv
// Scoreboard bench for i2s_transmitter: stimulus queues expected slot words,
// an independent monitor deserializes sdata and compares each finished slot.
module tb_i2s_transmitter;

  localparam int CLK_DIV    = 2;
  localparam int DATA_BITS  = 16;
  localparam int FRAC_SHIFT = 0;
  localparam int FIFO_DEPTH = 4;
  localparam int FRAME      = 128 * CLK_DIV;
  localparam int FS0        = 2 * CLK_DIV;   // first frame start after release

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] audio = '0;
  logic        valid = 1'b0;
  logic        clr = 1'b0;
  logic        sclk, lrclk, sdata, underrun, overflow;

  int errors = 0;
  int checks = 0;
  int cyc;
  bit mon_en = 1'b0;

  logic [30:0] exp_q [$];
  logic [31:0] stim  [$];

  always #5 clk = ~clk;

  i2s_transmitter #(
    .CLK_DIV    (CLK_DIV),
    .DATA_BITS  (DATA_BITS),
    .FRAC_SHIFT (FRAC_SHIFT),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk_in         (clk),
    .rst_n_in       (rst_n),
    .audio_in       (audio),
    .audio_valid_in (valid),
    .clear_flags_in (clr),
    .sclk_out       (sclk),
    .lrclk_out      (lrclk),
    .sdata_out      (sdata),
    .underrun_out   (underrun),
    .overflow_out   (overflow)
  );

  // Rising clk edges since the last reset release.
  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Slot bits 1..31 as seen on the wire: word MSB first, zero padded.
  function automatic logic [30:0] slot_of(input logic [DATA_BITS-1:0] w);
    return 31'(w) << (31 - DATA_BITS);
  endfunction

  task automatic expect_frames(input logic [DATA_BITS-1:0] w, input int n);
    for (int i = 0; i < 2 * n; i++) exp_q.push_back(slot_of(w));
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  // Push every queued stimulus word on consecutive cycles, first at edge n.
  task automatic push_q(input int n);
    wait_cyc(n - 1);
    while (stim.size() > 0) begin
      audio = stim.pop_front();
      valid = 1'b1;
      @(negedge clk);
    end
    valid = 1'b0;
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    valid = 1'b0;
    clr   = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;
  endtask

  task automatic drain(input string name);
    check(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  // Monitor: sample sdata on sclk rising edges; a word-select change closes a slot.
  logic        m_prev_sclk, m_prev_lr, m_active;
  int          m_k;
  logic [30:0] m_slot;
  always @(negedge clk) begin
    if (!rst_n || !mon_en) begin
      m_prev_sclk = 1'b0;
      m_prev_lr   = 1'b1;
      m_active    = 1'b0;
      m_k         = 0;
      m_slot      = '0;
    end else begin
      if (sclk && !m_prev_sclk) begin
        if (lrclk != m_prev_lr) begin
          if (m_active) begin
            if (exp_q.size() == 0) check("unexpected_slot", {1'b0, m_slot}, 32'hDEAD_BEEF);
            else                   check("slot", {1'b0, m_slot}, {1'b0, exp_q.pop_front()});
          end
          m_active = 1'b1;
          m_k      = 0;
          m_slot   = '0;
        end else if (m_active) begin
          m_k++;
          if (m_k <= 31) m_slot = {m_slot[29:0], sdata};
        end
        m_prev_lr = lrclk;
      end
      m_prev_sclk = sclk;
    end
  end

  initial begin
    int t1, t2;
    logic pl;

    // ---- one sample, replayed on underrun ----
    do_reset();
    expect_frames(16'h1234, 2);
    stim.push_back(32'h0000_1234);
    push_q(1);
    wait_cyc(100);
    check("underrun_before_replay", underrun, 1'b0);
    wait_cyc(FS0 + 2 * FRAME + 16);
    check("underrun_after_replay", underrun, 1'b1);
    check("overflow_idle", overflow, 1'b0);
    drain("pending_basic");

    // ---- width reduction ----
    do_reset();
`ifdef I2S_SATURATE_EN
    expect_frames(16'h7FFF, 1);
    expect_frames(16'h8000, 1);
`else
    expect_frames(16'h2345, 1);
    expect_frames(16'h0000, 1);
`endif
    expect_frames(16'h8000, 1);
    stim.push_back(32'h0001_2345);
    stim.push_back(32'hFFFE_0000);
    stim.push_back(32'hFFFF_8000);
    push_q(1);
    wait_cyc(FS0 + 3 * FRAME + 16);
    drain("pending_reduce");

    // ---- asynchronous reset mid right slot ----
    do_reset();
    exp_q.push_back(slot_of(16'hA5A5));
    stim.push_back(32'h0000_A5A5);
    stim.push_back(32'h0000_1111);
    push_q(1);
    wait_cyc(FS0 + 40 * 2 * CLK_DIV);
    mon_en = 1'b0;
    drain("pending_before_reset");
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("rst_sclk",  sclk, 1'b0);
    check("rst_lrclk", lrclk, 1'b1);
    check("rst_sdata", sdata, 1'b0);
    check("rst_flags", {underrun, overflow}, 2'b00);
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    expect_frames(16'h5A5A, 2);
    stim.push_back(32'h0000_5A5A);
    push_q(1);
    wait_cyc(FS0 + 2 * FRAME + 16);
    drain("pending_after_reset");

    // ---- idle: silence, underrun, lrclk period ----
    do_reset();
    check("idle_rst_lrclk", lrclk, 1'b1);
    check("idle_rst_underrun", underrun, 1'b0);
    expect_frames(16'h0000, 2);
    t1 = -1;
    t2 = -1;
    pl = lrclk;
    for (int i = 0; i < 3 * FRAME && t2 < 0; i++) begin
      @(negedge clk);
      if (lrclk && !pl) begin
        if (t1 < 0) t1 = cyc;
        else        t2 = cyc;
      end
      pl = lrclk;
    end
    if (t2 < 0) check("lrclk_edges_seen", 0, 1);
    else        check("lrclk_period", t2 - t1, FRAME);
    wait_cyc(FS0 + 2 * FRAME + 16);
    check("idle_underrun", underrun, 1'b1);
    drain("pending_idle");

    // ---- overflow: 5 pushes mid-frame, 5th dropped ----
    do_reset();
    expect_frames(16'h0000, 1);
    expect_frames(16'h1111, 1);
    expect_frames(16'h2222, 1);
    expect_frames(16'h3333, 1);
    expect_frames(16'h4444, 2);
    stim = '{32'h1111, 32'h2222, 32'h3333, 32'h4444, 32'h5555};
    push_q(21);
    wait_cyc(30);
    check("overflow_set", overflow, 1'b1);
    wait_cyc(FS0 + 6 * FRAME + 16);
    drain("pending_overflow");

    // ---- push into full FIFO on the frame-start pop ----
    do_reset();
    expect_frames(16'h0000, 1);
    expect_frames(16'hAAA1, 1);
    expect_frames(16'hAAA2, 1);
    expect_frames(16'hAAA3, 1);
    expect_frames(16'hAAA4, 1);
    expect_frames(16'h6666, 1);
    stim = '{32'hAAA1, 32'hAAA2, 32'hAAA3, 32'hAAA4};
    push_q(21);
    stim.push_back(32'h6666);
    push_q(FS0 + FRAME);
    wait_cyc(FS0 + FRAME + 10);
    check("no_overflow_on_pop", overflow, 1'b0);
    wait_cyc(FS0 + 6 * FRAME + 16);
    drain("pending_full_pop");

    // ---- clear vs set priority ----
    do_reset();
    mon_en = 1'b0;
    stim = '{32'h1, 32'h2, 32'h3, 32'h4};
    push_q(21);
    wait_cyc(24);
    audio = 32'h9999;
    valid = 1'b1;
    clr   = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    clr   = 1'b0;
    @(negedge clk);
    check("clear_vs_set_overflow", overflow, 1'b1);
    check("clear_cleared_underrun", underrun, 1'b0);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
    check("lone_clear_overflow", overflow, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
